// File: rtl/rglib_rotate_pipe_if.sv
// Handshake bundle for rglib_rotate_pipe: operand/op/amount in, result out.
interface rglib_rotate_pipe_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GRANULE    = 1
) ();
  localparam int unsigned AMT_W = $clog2(DATA_WIDTH / GRANULE);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [AMT_W-1:0]      in_amt;
  logic [1:0]            in_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rglib_rotate_pipe.sv
// Pipelined granule rotator/shifter (ROR/ROL/SRL/SRA) with the log-depth mux
// tree spread over PIPE_STAGES registered stages and valid/ready flow control.
module rglib_rotate_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned GRANULE     = 1,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               kill,
  rglib_rotate_pipe_if.slave bus
);
  localparam int unsigned AMT_W = $clog2(DATA_WIDTH / GRANULE);
  localparam int unsigned PS    = PIPE_STAGES;

  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_ROL = 2'b01,
    OP_SRL = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  logic [DATA_WIDTH-1:0] data_q   [PS];
  logic [DATA_WIDTH-1:0] data_d   [PS];
  logic [AMT_W-1:0]      amt_q    [PS];
  op_e                   op_q     [PS];
  logic [PS-1:0]         vld_q;

  logic [DATA_WIDTH-1:0] src_data [PS];
  logic [AMT_W-1:0]      src_amt  [PS];
  op_e                   src_op   [PS];
  logic [PS-1:0]         src_vld;
  logic [PS-1:0]         adv;

  function automatic int unsigned stage_of(input int unsigned j);
    return (j * PS) / AMT_W;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] level(input logic [DATA_WIDTH-1:0] d,
                                                  input op_e op, input int unsigned sh);
    logic [DATA_WIDTH-1:0] ones;
    logic [DATA_WIDTH-1:0] res;
    ones = '1;
    case (op)
      OP_ROR:  res = (d >> sh) | (d << (DATA_WIDTH - sh));
      OP_ROL:  res = (d << sh) | (d >> (DATA_WIDTH - sh));
      OP_SRL:  res = d >> sh;
      default: res = (d >> sh) | (d[DATA_WIDTH-1] ? ~(ones >> sh) : '0);
    endcase
    return res;
  endfunction

  // Stage k consumes either the bus (k=0) or the previous stage's registers.
  always_comb begin
    src_data[0] = bus.in_data;
    src_amt[0]  = bus.in_amt;
    src_op[0]   = op_e'(bus.in_op);
    src_vld     = '0;
    src_vld[0]  = bus.in_valid;
    for (int unsigned k = 1; k < PS; k++) begin
      src_data[k] = data_q[k-1];
      src_amt[k]  = amt_q[k-1];
      src_op[k]   = op_q[k-1];
      src_vld[k]  = vld_q[k-1];
    end
  end

  always_comb begin
    logic [DATA_WIDTH-1:0] t;
    for (int unsigned k = 0; k < PS; k++) begin
      t = src_data[k];
      for (int unsigned j = 0; j < AMT_W; j++) begin
        if (stage_of(j) == k && src_amt[k][j]) begin
          t = level(t, src_op[k], GRANULE << j);
        end
      end
      data_d[k] = t;
    end
  end

  // Advance chain walks from the output back to stage 0 through a scalar so
  // each stage only depends on the one in front of it.
  always_comb begin
    logic nxt;
    nxt = bus.out_ready;
    adv = '0;
    for (int unsigned i = 0; i < PS; i++) begin
      adv[PS-1-i] = !vld_q[PS-1-i] || nxt;
      nxt         = adv[PS-1-i];
    end
  end

  assign bus.in_ready  = adv[0] | kill;
  assign bus.out_valid = vld_q[PS-1];
  assign bus.out_data  = data_q[PS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < PS; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        op_q[k]   <= OP_ROR;
      end
    end else begin
      for (int unsigned k = 0; k < PS; k++) begin
        if (kill) begin
          vld_q[k] <= 1'b0;
        end else if (adv[k]) begin
          vld_q[k]  <= src_vld[k];
          data_q[k] <= data_d[k];
          amt_q[k]  <= src_amt[k];
          op_q[k]   <= src_op[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_rglib_rotate_pipe.sv
// Bench for rglib_rotate_pipe: cycle-level queue model for a 32b/G1/2-stage
// instance plus directed and random checks on a 32b/G8/1-stage instance.
module tb_rglib_rotate_pipe;
  localparam int unsigned PS_A = 2;

  logic clk;
  logic rst_n;
  logic kill_a;
  logic kill_b;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;
  int unsigned m = 0;

  rglib_rotate_pipe_if #(.DATA_WIDTH(32), .GRANULE(1)) ifa ();
  rglib_rotate_pipe_if #(.DATA_WIDTH(32), .GRANULE(8)) ifb ();

  rglib_rotate_pipe #(.DATA_WIDTH(32), .GRANULE(1), .PIPE_STAGES(PS_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .kill(kill_a), .bus(ifa)
  );
  rglib_rotate_pipe #(.DATA_WIDTH(32), .GRANULE(8), .PIPE_STAGES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .kill(kill_b), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [31:0] d, input int unsigned s,
                                         input logic [1:0] op);
    logic [63:0]        w;
    logic signed [31:0] sd;
    w  = {d, d};
    sd = d;
    case (op)
      2'b00:   begin w = w >> s; return w[31:0];  end
      2'b01:   begin w = w << s; return w[63:32]; end
      2'b10:   return d >> s;
      default: return sd >>> s;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Model: in-flight queue; each entry becomes visible at a given edge count.
  typedef struct {
    logic [31:0] d;
    int unsigned vis;
  } ent_t;
  ent_t q[$];

  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      m++;
      if (kill_a) begin
        q.delete();
      end else begin
        if (ifa.out_valid && ifa.out_ready && q.size() > 0) begin
          void'(q.pop_front());
          if (q.size() > 0 && q[0].vis < m) q[0].vis = m;
        end
        if (ifa.in_valid && ifa.in_ready)
          q.push_back('{d: ref_op(ifa.in_data, ifa.in_amt, ifa.in_op), vis: m + PS_A - 1});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      logic exp_v;
      exp_v = q.size() > 0 && m >= q[0].vis;
      chk("a_out_valid", {31'b0, ifa.out_valid}, {31'b0, exp_v});
      if (exp_v) chk("a_out_data", ifa.out_data, q[0].d);
      chk("a_in_ready", {31'b0, ifa.in_ready},
          {31'b0, (q.size() < PS_A) || ifa.out_ready || kill_a});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [31:0] d, input logic [4:0] amt,
                       input logic [1:0] op);
    ifa.in_valid = v;
    ifa.in_data  = d;
    ifa.in_amt   = amt;
    ifa.in_op    = op;
  endtask

  task automatic send_a(input string name, input logic [31:0] d, input logic [4:0] amt,
                        input logic [1:0] op, input logic [31:0] exp);
    set_a(1'b1, d, amt, op);
    #1;
    chk({name, "_in_ready"}, {31'b0, ifa.in_ready}, 32'd1);
    step();
    ifa.in_valid = 1'b0;
    chk({name, "_early"}, {31'b0, ifa.out_valid}, 32'd0);
    step();
    chk({name, "_valid"}, {31'b0, ifa.out_valid}, 32'd1);
    chk(name, ifa.out_data, exp);
    step();
  endtask

  task automatic send_b(input string name, input logic [31:0] d, input logic [1:0] amt,
                        input logic [1:0] op, input logic [31:0] exp);
    ifb.in_valid = 1'b1;
    ifb.in_data  = d;
    ifb.in_amt   = amt;
    ifb.in_op    = op;
    #1;
    chk({name, "_in_ready"}, {31'b0, ifb.in_ready}, 32'd1);
    step();
    ifb.in_valid = 1'b0;
    chk({name, "_valid"}, {31'b0, ifb.out_valid}, 32'd1);
    chk(name, ifb.out_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, got, stall, gaps;
    bit ir_low, acc, cons;
    logic [31:0] held, bexp;

    rst_n = 1'b0; kill_a = 1'b0; kill_b = 1'b0;
    set_a(1'b0, '0, '0, '0);
    ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_amt = '0; ifb.in_op = '0;
    ifb.out_ready = 1'b1;

    chk("ref_ror1", ref_op(32'h80000001, 1, 2'b00), 32'hC0000000);
    chk("ref_rol4", ref_op(32'h80000001, 4, 2'b01), 32'h00000018);
    chk("ref_sra31", ref_op(32'h80000000, 31, 2'b11), 32'hFFFFFFFF);
    chk("ref_ror8", ref_op(32'h11223344, 8, 2'b00), 32'h44112233);

    #12;
    chk("rst_a_valid", {31'b0, ifa.out_valid}, 32'd0);
    chk("rst_a_data", ifa.out_data, 32'd0);
    chk("rst_b_valid", {31'b0, ifb.out_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    chk_en = 1'b1;
    chk("post_rst_in_ready", {31'b0, ifa.in_ready}, 32'd1);

    send_a("ror1", 32'h80000001, 5'd1, 2'b00, 32'hC0000000);
    send_a("rol4", 32'h80000001, 5'd4, 2'b01, 32'h00000018);
    for (int op = 0; op < 4; op++)
      send_a("amt0", 32'h80000001, 5'd0, 2'(op), 32'h80000001);
    send_a("sra31", 32'h80000000, 5'd31, 2'b11, 32'hFFFFFFFF);
    send_a("srl31", 32'h80000000, 5'd31, 2'b10, 32'h00000001);
    send_a("sra30", 32'h40000000, 5'd30, 2'b11, 32'h00000001);

    send_b("b_ror1", 32'h11223344, 2'd1, 2'b00, 32'h44112233);
    send_b("b_rol3", 32'h11223344, 2'd3, 2'b01, 32'h44112233);
    send_b("b_srl2", 32'h11223344, 2'd2, 2'b10, 32'h00001122);
    send_b("b_sra1", 32'h80000000, 2'd1, 2'b11, 32'hFF800000);
    step();

    // Backpressure: five back-to-back ops, output stalled 4 cycles.
    sent = 0; got = 0; stall = 0; gaps = 0; ir_low = 0; held = '0;
    ifa.out_ready = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (sent < 5) set_a(1'b1, $urandom, 5'($urandom), 2'($urandom));
      else ifa.in_valid = 1'b0;
      if (ifa.out_valid && stall < 4) begin
        if (stall == 0) held = ifa.out_data;
        else chk("bp_hold", ifa.out_data, held);
        ifa.out_ready = 1'b0;
        stall++;
      end else if (stall >= 4) begin
        ifa.out_ready = 1'b1;
        if (!ifa.out_valid) gaps++;
      end
      #1;
      if (!ifa.in_ready) ir_low = 1'b1;
      acc  = ifa.in_valid && ifa.in_ready;
      cons = ifa.out_valid && ifa.out_ready;
      step();
      if (acc) sent++;
      if (cons) got++;
    end
    chk("bp_sent", sent, 32'd5);
    chk("bp_got", got, 32'd5);
    chk("bp_in_ready_low", {31'b0, ir_low}, 32'd1);
    chk("bp_gaps", gaps, 32'd0);
    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    step();

    // Kill with two in flight and a valid input on the kill cycle.
    set_a(1'b1, 32'h0000F00D, 5'd3, 2'b00);
    step();
    set_a(1'b1, 32'h12345678, 5'd7, 2'b01);
    step();
    set_a(1'b1, 32'hDEADBEEF, 5'd1, 2'b10);
    kill_a = 1'b1;
    #1;
    chk("kill_in_ready", {31'b0, ifa.in_ready}, 32'd1);
    step();
    kill_a = 1'b0;
    ifa.in_valid = 1'b0;
    chk("kill_out_valid", {31'b0, ifa.out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("kill_quiet", {31'b0, ifa.out_valid}, 32'd0);
    end
    send_a("post_kill", 32'h00000003, 5'd2, 2'b01, 32'h0000000C);

    // Asynchronous reset between edges with two in flight.
    set_a(1'b1, 32'hA5A5A5A5, 5'd4, 2'b00);
    step();
    set_a(1'b1, 32'h5A5A5A5A, 5'd9, 2'b11);
    step();
    ifa.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, ifa.out_valid}, 32'd0);
    chk("arst_data", ifa.out_data, 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("arst_in_ready", {31'b0, ifa.in_ready}, 32'd1);
    send_a("post_rst", 32'h00000001, 5'd1, 2'b00, 32'h80000000);

    // Random traffic on both instances.
    for (int c = 0; c < 1500; c++) begin
      set_a($urandom_range(0, 3) != 0, $urandom, 5'($urandom), 2'($urandom));
      ifa.out_ready = $urandom_range(0, 2) != 0;
      kill_a = $urandom_range(0, 39) == 0;
      ifb.in_valid = 1'b1;
      ifb.in_data  = $urandom;
      ifb.in_amt   = 2'($urandom_range(0, 3));
      ifb.in_op    = 2'($urandom);
      bexp = ref_op(ifb.in_data, 8 * ifb.in_amt, ifb.in_op);
      step();
      chk("b_rand_valid", {31'b0, ifb.out_valid}, 32'd1);
      chk("b_rand_data", ifb.out_data, bexp);
    end

    ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b1;
    kill_a = 1'b0;
    ifb.in_valid = 1'b0;
    repeat (5) step();
    chk("drain_a", {31'b0, ifa.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
